// File: rtl/zesal_walker.sv
`default_nettype none
// ============================================================================
//  Module   : zesal_walker
//  Purpose  : Tree-search sequencer. Issues Find commands down a chain of Zesal
//             nodes and returns one result record per request.
//  Revision : 1.0  initial release
// ============================================================================
module zesal_walker #(
  parameter int KEYS_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int NEXT_BITS = 8,
  parameter int CMD_BITS  = 8,
  parameter int MAX_DEPTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [KEYS_BITS-1:0] req_key,
  input  logic [NEXT_BITS-1:0] req_root,
  output logic                 node_valid,
  input  logic                 node_ready,
  output logic [CMD_BITS-1:0]  node_cmd,
  output logic [NEXT_BITS-1:0] node_ptr,
  output logic [KEYS_BITS-1:0] node_key,
  input  logic                 rsp_valid,
  input  logic [CMD_BITS-1:0]  rsp_cmd,
  input  logic [DATA_BITS-1:0] rsp_data,
  input  logic [NEXT_BITS-1:0] rsp_next,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [1:0]           res_status,
  output logic [DATA_BITS-1:0] res_data,
  output logic [3:0]           res_depth
);

  localparam logic [3:0]          c_MAX_DEPTH   = 4'(MAX_DEPTH);
  localparam logic [7:0]          c_TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [CMD_BITS-1:0] c_CMD_FIND    = CMD_BITS'(2);
  localparam logic [CMD_BITS-1:0] c_CMD_FOUND   = CMD_BITS'(3);
  localparam logic [CMD_BITS-1:0] c_CMD_DESCEND = CMD_BITS'(7);
  localparam logic [1:0]          c_ST_FOUND    = 2'd0;
  localparam logic [1:0]          c_ST_MISS     = 2'd1;
  localparam logic [1:0]          c_ST_DEPTH    = 2'd2;
  localparam logic [1:0]          c_ST_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state,  w_state_nx;
  logic [KEYS_BITS-1:0] r_key,    w_key_nx;
  logic [NEXT_BITS-1:0] r_ptr,    w_ptr_nx;
  logic [3:0]           r_depth,  w_depth_nx;
  logic [7:0]           r_timer,  w_timer_nx;
  logic [1:0]           r_status, w_status_nx;
  logic [DATA_BITS-1:0] r_data,   w_data_nx;
  logic [3:0]           w_depth_inc;

  assign w_depth_inc = r_depth + 4'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_key    <= '0;
      r_ptr    <= '0;
      r_depth  <= '0;
      r_timer  <= '0;
      r_status <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_key    <= w_key_nx;
      r_ptr    <= w_ptr_nx;
      r_depth  <= w_depth_nx;
      r_timer  <= w_timer_nx;
      r_status <= w_status_nx;
      r_data   <= w_data_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_key_nx    = r_key;
    w_ptr_nx    = r_ptr;
    w_depth_nx  = r_depth;
    w_timer_nx  = r_timer;
    w_status_nx = r_status;
    w_data_nx   = r_data;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_key_nx   = req_key;
          w_ptr_nx   = req_root;
          w_depth_nx = '0;
          w_timer_nx = '0;
          w_data_nx  = '0;
          if (req_root == '0) begin
            w_status_nx = c_ST_MISS;
            w_state_nx  = S_DONE;
          end else begin
            w_state_nx  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (node_ready) begin
          w_timer_nx = '0;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the expiry cycle takes priority over the timeout.
        if (rsp_valid) begin
          w_depth_nx = w_depth_inc;
          if (rsp_cmd == c_CMD_FOUND) begin
            w_status_nx = c_ST_FOUND;
            w_data_nx   = rsp_data;
            w_state_nx  = S_DONE;
          end else if (rsp_cmd == c_CMD_DESCEND && rsp_next != '0) begin
            if (w_depth_inc == c_MAX_DEPTH) begin
              w_status_nx = c_ST_DEPTH;
              w_state_nx  = S_DONE;
            end else begin
              w_ptr_nx   = rsp_next;
              w_state_nx = S_ISSUE;
            end
          end else begin
            w_status_nx = c_ST_MISS;
            w_state_nx  = S_DONE;
          end
        end else if (r_timer == c_TMO_LAST) begin
          w_status_nx = c_ST_TIMEOUT;
          w_state_nx  = S_DONE;
        end else begin
          w_timer_nx = r_timer + 8'd1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Gating with reset keeps req_ready low for the whole time reset is held.
  assign req_ready  = (r_state == S_IDLE) && reset;
  assign node_valid = (r_state == S_ISSUE);
  assign node_cmd   = node_valid ? c_CMD_FIND : '0;
  assign node_ptr   = r_ptr;
  assign node_key   = r_key;
  assign res_valid  = (r_state == S_DONE);
  assign res_status = r_status;
  assign res_data   = r_data;
  assign res_depth  = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_zesal_walker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zesal_walker
//  Purpose  : Directed self-checking bench for zesal_walker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zesal_walker;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_key;
  logic [7:0] req_root;
  logic       node_valid;
  logic       node_ready;
  logic [7:0] node_cmd;
  logic [7:0] node_ptr;
  logic [7:0] node_key;
  logic       rsp_valid;
  logic [7:0] rsp_cmd;
  logic [7:0] rsp_data;
  logic [7:0] rsp_next;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_status;
  logic [7:0] res_data;
  logic [3:0] res_depth;

  int tests = 0;
  int fails = 0;
  int find_cnt = 0;
  logic [7:0] find_log [0:63];

  zesal_walker #(
    .KEYS_BITS(8), .DATA_BITS(8), .NEXT_BITS(8), .CMD_BITS(8),
    .MAX_DEPTH(8), .TIMEOUT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_root(req_root),
    .node_valid(node_valid), .node_ready(node_ready), .node_cmd(node_cmd),
    .node_ptr(node_ptr), .node_key(node_key),
    .rsp_valid(rsp_valid), .rsp_cmd(rsp_cmd), .rsp_data(rsp_data), .rsp_next(rsp_next),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
    .res_data(res_data), .res_depth(res_depth)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Passive log of every accepted Find command.
  always @(posedge clock) begin
    if (node_valid && node_ready) begin
      if (find_cnt < 64) find_log[find_cnt] = node_ptr;
      find_cnt = find_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send_req(input logic [7:0] key, input logic [7:0] root);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL req_wait: req_ready=%0d required 1", req_ready);
    end
    req_key = key; req_root = root; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Accept one Find, then answer after lat cycles (lat >= 1).
  task automatic serve(input logic [7:0] cmd, input logic [7:0] data,
                       input logic [7:0] nxt, input int lat);
    int n = 0;
    while (!node_valid && n < 50) begin tick(); n++; end
    if (!node_valid) begin
      tests++; fails++;
      $display("FAIL node_wait: node_valid=%0d required 1", node_valid);
    end
    node_ready = 1'b1;
    tick();
    node_ready = 1'b0;
    repeat (lat - 1) tick();
    rsp_valid = 1'b1; rsp_cmd = cmd; rsp_data = data; rsp_next = nxt;
    tick();
    rsp_valid = 1'b0; rsp_cmd = 8'h00; rsp_data = 8'h00; rsp_next = 8'h00;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    if (!res_valid) begin
      tests++; fails++;
      $display("FAIL res_wait: res_valid=%0d required 1", res_valid);
    end
  endtask

  task automatic take_res;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %0d want 0", req_ready); end
    tests++; if (node_valid !== 1'b0) begin fails++; $display("FAIL rst_node_valid: got %0d want 0", node_valid); end
    tests++; if (node_cmd !== 8'd0) begin fails++; $display("FAIL rst_node_cmd: got %0d want 0", node_cmd); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid: got %0d want 0", res_valid); end
    tests++; if ({res_status, res_data, res_depth} !== 14'd0) begin
      fails++; $display("FAIL rst_res_fields: status=%0d data=%0h depth=%0d want 0/0/0", res_status, res_data, res_depth);
    end
    reset = 1'b1;
    tick();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %0d want 1", req_ready); end
  endtask

  task automatic test_found;
    int f0 = find_cnt;
    int n;
    send_req(8'h2A, 8'd5);
    tests++; if (node_valid !== 1'b1 || node_ptr !== 8'd5 || node_key !== 8'h2A || node_cmd !== 8'd2) begin
      fails++; $display("FAIL found_issue: valid=%0d ptr=%0d key=%0h cmd=%0d want 1/5/2a/2", node_valid, node_ptr, node_key, node_cmd);
    end
    serve(8'd3, 8'h77, 8'd0, 2);
    wait_res(n);
    tests++; if (res_status !== 2'd0 || res_data !== 8'h77 || res_depth !== 4'd1) begin
      fails++; $display("FAIL found_res: status=%0d data=%0h depth=%0d want 0/77/1", res_status, res_data, res_depth);
    end
    tests++; if (find_cnt - f0 != 1 || find_log[f0] !== 8'd5) begin
      fails++; $display("FAIL found_finds: count=%0d ptr=%0d want 1/5", find_cnt - f0, find_log[f0]);
    end
    take_res();
  endtask

  task automatic test_descend;
    int f0 = find_cnt;
    int n;
    send_req(8'h10, 8'd1);
    serve(8'd7, 8'h00, 8'd4, 2);
    serve(8'd7, 8'h00, 8'd9, 2);
    serve(8'd3, 8'h11, 8'd0, 2);
    wait_res(n);
    tests++; if (res_status !== 2'd0 || res_data !== 8'h11 || res_depth !== 4'd3) begin
      fails++; $display("FAIL desc_res: status=%0d data=%0h depth=%0d want 0/11/3", res_status, res_data, res_depth);
    end
    tests++; if (find_cnt - f0 != 3 || find_log[f0] !== 8'd1 || find_log[f0+1] !== 8'd4 || find_log[f0+2] !== 8'd9) begin
      fails++; $display("FAIL desc_finds: count=%0d ptrs=%0d,%0d,%0d want 3 finds 1,4,9",
                        find_cnt - f0, find_log[f0], find_log[f0+1], find_log[f0+2]);
    end
    take_res();
  endtask

  task automatic test_miss;
    int f0 = find_cnt;
    int n;
    send_req(8'h01, 8'd0);
    tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL null_latency: res_valid=%0d want 1", res_valid); end
    tests++; if (res_status !== 2'd1 || res_depth !== 4'd0 || find_cnt != f0) begin
      fails++; $display("FAIL null_res: status=%0d depth=%0d finds=%0d want 1/0/0", res_status, res_depth, find_cnt - f0);
    end
    take_res();
    send_req(8'h02, 8'd2);
    serve(8'd0, 8'h55, 8'd0, 2);
    wait_res(n);
    tests++; if (res_status !== 2'd1 || res_depth !== 4'd1 || res_data !== 8'h00) begin
      fails++; $display("FAIL miss_res: status=%0d depth=%0d data=%0h want 1/1/0", res_status, res_depth, res_data);
    end
    take_res();
  endtask

  task automatic test_depth;
    int f0 = find_cnt;
    int n;
    send_req(8'h33, 8'd3);
    for (int i = 0; i < 8; i++) serve(8'd7, 8'h00, 8'd3, 1);
    wait_res(n);
    tests++; if (res_status !== 2'd2 || res_depth !== 4'd8) begin
      fails++; $display("FAIL depth_res: status=%0d depth=%0d want 2/8", res_status, res_depth);
    end
    tests++; if (find_cnt - f0 != 8 || node_valid !== 1'b0) begin
      fails++; $display("FAIL depth_finds: count=%0d node_valid=%0d want 8/0", find_cnt - f0, node_valid);
    end
    take_res();
  endtask

  task automatic test_timeout;
    int k = 0;
    int n;
    send_req(8'h44, 8'd6);
    node_ready = 1'b1;
    tick();
    node_ready = 1'b0;
    while (!res_valid && k < 100) begin tick(); k++; end
    tests++; if (k != 16) begin fails++; $display("FAIL tmo_latency: cycles=%0d want 16", k); end
    tests++; if (res_status !== 2'd3 || res_depth !== 4'd0) begin
      fails++; $display("FAIL tmo_res: status=%0d depth=%0d want 3/0", res_status, res_depth);
    end
    take_res();
    send_req(8'h45, 8'd6);
    node_ready = 1'b1;
    tick();
    node_ready = 1'b0;
    repeat (15) tick();
    rsp_valid = 1'b1; rsp_cmd = 8'd3; rsp_data = 8'h99;
    tick();
    rsp_valid = 1'b0; rsp_cmd = 8'd0; rsp_data = 8'd0;
    wait_res(n);
    tests++; if (res_status !== 2'd0 || res_data !== 8'h99 || res_depth !== 4'd1) begin
      fails++; $display("FAIL tmo_race: status=%0d data=%0h depth=%0d want 0/99/1", res_status, res_data, res_depth);
    end
    take_res();
  endtask

  task automatic test_backpressure;
    int n;
    send_req(8'h3C, 8'd8);
    for (int i = 0; i < 5; i++) begin
      tests++; if (node_valid !== 1'b1 || node_ptr !== 8'd8 || node_key !== 8'h3C || node_cmd !== 8'd2) begin
        fails++; $display("FAIL bp_node_hold: cyc=%0d valid=%0d ptr=%0d key=%0h cmd=%0d want 1/8/3c/2",
                          i, node_valid, node_ptr, node_key, node_cmd);
      end
      tick();
    end
    serve(8'd3, 8'h42, 8'd0, 1);
    wait_res(n);
    for (int i = 0; i < 4; i++) begin
      tests++; if (res_valid !== 1'b1 || res_status !== 2'd0 || res_data !== 8'h42 || res_depth !== 4'd1 || req_ready !== 1'b0) begin
        fails++; $display("FAIL bp_res_hold: cyc=%0d valid=%0d status=%0d data=%0h depth=%0d req_ready=%0d want 1/0/42/1/0",
                          i, res_valid, res_status, res_data, res_depth, req_ready);
      end
      tick();
    end
    take_res();
    tests++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: res_valid=%0d req_ready=%0d want 0/1", res_valid, req_ready);
    end
  endtask

  task automatic test_reset_wait;
    send_req(8'h55, 8'd7);
    node_ready = 1'b1;
    tick();
    node_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstw_ready: got %0d want 1", req_ready); end
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b0 || node_valid !== 1'b0) begin
        tests++; fails++;
        $display("FAIL rstw_silent: cyc=%0d res_valid=%0d node_valid=%0d want 0/0", i, res_valid, node_valid);
        break;
      end
      tick();
    end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rstw_no_result: got %0d want 0", res_valid); end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_key = '0; req_root = '0;
    node_ready = 1'b0; rsp_valid = 1'b0; rsp_cmd = '0; rsp_data = '0; rsp_next = '0;
    res_ready = 1'b0;
    test_reset();
    test_found();
    test_descend();
    test_miss();
    test_depth();
    test_timeout();
    test_backpressure();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zesal_walker.md
Name: zesal_walker

Overview:
- Tree-search sequencer directly upstream of the Zesal node array.
- Accepts a find request (key plus root node pointer) and issues Find commands to successive Zesal nodes.
- Consumes each node response: follows next pointers downward until the key is found, a miss is reported, the depth limit is hit, or a node fails to answer.
- Returns a single result record per request over a valid/ready handshake.

Parameters:
- KEYS_BITS, 8, bits in a key
- DATA_BITS, 8, bits in data associated with a key
- NEXT_BITS, 8, bits in a node pointer; pointer value 0 is null
- CMD_BITS, 8, width of the node command/response code
- MAX_DEPTH, 8, maximum nodes visited per request (1..15)
- TIMEOUT, 16, cycles waited for a node response before abort (1..255)

Ports:
- clock  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  request offered
- req_ready  output  1  walker can accept a request
- req_key  input  KEYS_BITS  key sought
- req_root  input  NEXT_BITS  pointer to the root node
- node_valid  output  1  command to node array valid
- node_ready  input  1  node array accepts command
- node_cmd  output  CMD_BITS  command code; always 2 (Find) when node_valid
- node_ptr  output  NEXT_BITS  node addressed
- node_key  output  KEYS_BITS  key sought
- rsp_valid  input  1  node response valid (single-cycle pulse)
- rsp_cmd  input  CMD_BITS  3 = Found, 7 = Descend, anything else = Miss
- rsp_data  input  DATA_BITS  data for Found
- rsp_next  input  NEXT_BITS  child pointer for Descend
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_status  output  2  0 found, 1 miss, 2 depth exceeded, 3 timeout
- res_data  output  DATA_BITS  found data, 0 otherwise
- res_depth  output  4  nodes visited, 0..MAX_DEPTH

Behaviour:
- Reset (reset==0 at a rising edge):
  - state IDLE.
  - All outputs 0 (req_ready 0 while reset is asserted).
  - Internal key, pointer, depth and timer cleared.
  - Reset mid-walk aborts the walk silently; no result is produced.
- FSM states IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid&&req_ready: latch key, ptr=req_root, depth=0.
  - If req_root==0, go to DONE with status 1 (miss), depth 0.
  - Otherwise go to ISSUE.
- ISSUE:
  - node_valid=1, node_cmd=2, node_ptr=ptr, node_key=key.
  - These stay stable until node_ready; on handshake go to WAIT with timer=0.
  - node_valid is 0 in every other state.
- WAIT:
  - timer increments each cycle with no rsp_valid.
  - rsp_valid is ignored in all states except WAIT.
  - On rsp_valid, depth increments, then:
    - rsp_cmd==3: DONE, status 0, res_data=rsp_data.
    - rsp_cmd==7 and rsp_next!=0: if the new depth==MAX_DEPTH, DONE with status 2; else ptr=rsp_next and go to ISSUE.
    - rsp_cmd==7 with rsp_next==0, or any other code: DONE, status 1.
  - If timer reaches TIMEOUT-1 with no response: DONE, status 3; depth is not incremented.
  - rsp_valid in the same cycle as timeout expiry: the response wins.
- DONE:
  - res_valid=1; res_status/res_data/res_depth held stable until res_ready.
  - On handshake: go to IDLE, res_valid=0 next cycle.
  - req_ready rises the cycle after the result handshake; no same-cycle accept.
- Latency:
  - Best case, request handshake to res_valid = 1 cycle (null root).
  - Per level = 1 issue cycle + node stall cycles + response latency.
- Width: depth counter is 4 bits; MAX_DEPTH is at most 15, so no wrap.

Test Plan:
- Root=5, key=0x2A; node answers Found (3) with data 0x77 two cycles after accept -> res_status 0, res_data 0x77, res_depth 1, one Find issued with node_ptr 5.
- Root=1; responses Descend next=4, Descend next=9, Found data 0x11 -> Finds to pointers 1, 4, 9 in order; result status 0, data 0x11, depth 3.
- Root=0 -> no node_valid ever; res_valid after 1 cycle, status 1, depth 0; root=2 with rsp_cmd 3 replaced by code 0 -> status 1, depth 1, res_data 0.
- MAX_DEPTH=8, node always answers Descend next=3 -> exactly 8 Finds issued; status 2, depth 8.
- Node never answers, TIMEOUT=16 -> result status 3 exactly 16 cycles after the command handshake; a further variant with rsp_valid on that expiry cycle -> the response is used instead.
- Backpressure: node_ready low 5 cycles -> node_* signals held stable; res_ready low 4 cycles -> result held, req_ready stays 0. Also reset asserted in WAIT -> no result, req_ready 1 one cycle after release.
